// File: rtl/eth_frame_rx.sv
// Ethernet II frame receiver: parses the 14-byte header, filters on destination
// MAC and ethertype, and steers the payload to an IPv4 or an ARP byte stream.
module eth_frame_rx #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [47:0]          mac_addr,
  input  logic [7:0]           axis_tdata_in,
  input  logic                 axis_tvalid_in,
  input  logic                 axis_tlast_in,
  output logic                 axis_tready_o,
  output logic [7:0]           ip_tdata_out,
  output logic                 ip_tvalid_out,
  output logic                 ip_tlast_out,
  input  logic                 ip_tready_in,
  output logic [7:0]           arp_tdata_out,
  output logic                 arp_tvalid_out,
  output logic                 arp_tlast_out,
  input  logic                 arp_tready_in,
  output logic [47:0]          src_mac_out,
  output logic [15:0]          ethertype_out,
  output logic                 hdr_valid_out,
  output logic [CNT_WIDTH-1:0] frames_ok_out,
  output logic [CNT_WIDTH-1:0] frames_drop_out
);

  typedef enum logic [1:0] {HDR, PAY_IP, PAY_ARP, DROP} state_t;

  localparam logic [15:0] TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] TYPE_ARP  = 16'h0806;

  state_t               state_reg, state_next;
  logic [3:0]           byte_cnt_reg;
  logic                 local_ok_reg, bcast_ok_reg;
  logic [47:0]          src_shift_reg;
  logic [7:0]           type_hi_reg;
  logic [47:0]          src_mac_reg;
  logic [15:0]          ethertype_reg;
  logic                 hdr_valid_reg;
  logic [CNT_WIDTH-1:0] frames_ok_reg, frames_drop_reg;

  logic [7:0]           mac_byte [0:7];
  logic [7:0]           ch_tdata_reg [0:1];
  logic                 ch_tvalid_reg [0:1];
  logic                 ch_tlast_reg [0:1];
  logic                 ch_tready [0:1];
  logic                 ch_sel [0:1];

  logic                 accept;
  logic                 hdr_last;
  logic                 dst_ok;
  logic                 to_payload;
  logic [15:0]          type_word;
  logic                 ok_inc, drop_inc;

  // Byte-addressable view of the local MAC; entries 6 and 7 only pad the 3-bit index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mac_byte
      if (gi < 6) begin : g_used
        assign mac_byte[gi] = mac_addr[47-8*gi -: 8];
      end else begin : g_pad
        assign mac_byte[gi] = 8'h00;
      end
    end
  endgenerate

  assign accept     = axis_tvalid_in && axis_tready_o;
  assign hdr_last   = (state_reg == HDR) && accept && (byte_cnt_reg == 4'd13) && !axis_tlast_in;
  assign dst_ok     = local_ok_reg || bcast_ok_reg;
  assign type_word  = {type_hi_reg, axis_tdata_in};
  assign to_payload = hdr_last && ((state_next == PAY_IP) || (state_next == PAY_ARP));

  assign ch_sel[0]    = (state_reg == PAY_IP);
  assign ch_sel[1]    = (state_reg == PAY_ARP);
  assign ch_tready[0] = ip_tready_in;
  assign ch_tready[1] = arp_tready_in;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= HDR;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR: begin
        if (hdr_last) begin
          if (dst_ok && (type_word == TYPE_IPV4)) begin
            state_next = PAY_IP;
          end else if (dst_ok && (type_word == TYPE_ARP)) begin
            state_next = PAY_ARP;
          end else begin
            state_next = DROP;
          end
        end
      end
      PAY_IP, PAY_ARP, DROP: begin
        if (accept && axis_tlast_in) begin
          state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end

  // FSM outputs: payload states only accept when the selected output slot can take a byte
  always_comb begin
    axis_tready_o = 1'b1;
    case (state_reg)
      PAY_IP:  axis_tready_o = !ch_tvalid_reg[0] || ip_tready_in;
      PAY_ARP: axis_tready_o = !ch_tvalid_reg[1] || arp_tready_in;
      default: axis_tready_o = 1'b1;
    endcase
  end

  // Header parsing: destination match flags, source MAC shift, ethertype high byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_reg  <= 4'd0;
      local_ok_reg  <= 1'b0;
      bcast_ok_reg  <= 1'b0;
      src_shift_reg <= 48'h0;
      type_hi_reg   <= 8'h00;
    end else if ((state_reg == HDR) && accept) begin
      if (axis_tlast_in || (byte_cnt_reg == 4'd13)) begin
        byte_cnt_reg <= 4'd0;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + 4'd1;
      end
      if (byte_cnt_reg < 4'd6) begin
        local_ok_reg <= ((byte_cnt_reg == 4'd0) || local_ok_reg)
                        && (axis_tdata_in == mac_byte[byte_cnt_reg[2:0]]);
        bcast_ok_reg <= ((byte_cnt_reg == 4'd0) || bcast_ok_reg)
                        && (axis_tdata_in == 8'hFF);
      end
      if ((byte_cnt_reg >= 4'd6) && (byte_cnt_reg <= 4'd11)) begin
        src_shift_reg <= {src_shift_reg[39:0], axis_tdata_in};
      end
      if (byte_cnt_reg == 4'd12) begin
        type_hi_reg <= axis_tdata_in;
      end
    end
  end

  // Published header metadata only changes for frames that are actually forwarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_mac_reg   <= 48'h0;
      ethertype_reg <= 16'h0;
      hdr_valid_reg <= 1'b0;
    end else begin
      hdr_valid_reg <= to_payload;
      if (to_payload) begin
        src_mac_reg   <= src_shift_reg;
        ethertype_reg <= type_word;
      end
    end
  end

  // One output register per channel; a drain and a new load in the same cycle overwrite
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ch_tdata_reg[gi]  <= 8'h00;
          ch_tvalid_reg[gi] <= 1'b0;
          ch_tlast_reg[gi]  <= 1'b0;
        end else if (accept && ch_sel[gi]) begin
          ch_tdata_reg[gi]  <= axis_tdata_in;
          ch_tvalid_reg[gi] <= 1'b1;
          ch_tlast_reg[gi]  <= axis_tlast_in;
        end else if (ch_tready[gi]) begin
          ch_tvalid_reg[gi] <= 1'b0;
          ch_tlast_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  // Frame statistics, saturating at all-ones
  assign ok_inc   = accept && axis_tlast_in && ((state_reg == PAY_IP) || (state_reg == PAY_ARP));
  assign drop_inc = accept && axis_tlast_in && ((state_reg == HDR) || (state_reg == DROP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_ok_reg   <= '0;
      frames_drop_reg <= '0;
    end else begin
      if (ok_inc && (frames_ok_reg != '1)) begin
        frames_ok_reg <= frames_ok_reg + 1'b1;
      end
      if (drop_inc && (frames_drop_reg != '1)) begin
        frames_drop_reg <= frames_drop_reg + 1'b1;
      end
    end
  end

  assign ip_tdata_out    = ch_tdata_reg[0];
  assign ip_tvalid_out   = ch_tvalid_reg[0];
  assign ip_tlast_out    = ch_tlast_reg[0];
  assign arp_tdata_out   = ch_tdata_reg[1];
  assign arp_tvalid_out  = ch_tvalid_reg[1];
  assign arp_tlast_out   = ch_tlast_reg[1];
  assign src_mac_out     = src_mac_reg;
  assign ethertype_out   = ethertype_reg;
  assign hdr_valid_out   = hdr_valid_reg;
  assign frames_ok_out   = frames_ok_reg;
  assign frames_drop_out = frames_drop_reg;

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed bench for eth_frame_rx: header filtering, payload steering, runts,
// output back-pressure, counter saturation and mid-frame reset.
module tb_eth_frame_rx;

  localparam int CW = 3;
  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER  = 48'h11_22_33_44_55_66;
  localparam logic [47:0] SRC1   = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] SRC2   = 48'h66_55_44_33_22_11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [47:0]   mac_addr = MY_MAC;
  logic [7:0]    axis_tdata_in = 8'h00;
  logic          axis_tvalid_in = 1'b0;
  logic          axis_tlast_in = 1'b0;
  logic          axis_tready_o;
  logic [7:0]    ip_tdata_out;
  logic          ip_tvalid_out;
  logic          ip_tlast_out;
  logic          ip_tready_in = 1'b1;
  logic [7:0]    arp_tdata_out;
  logic          arp_tvalid_out;
  logic          arp_tlast_out;
  logic          arp_tready_in = 1'b1;
  logic [47:0]   src_mac_out;
  logic [15:0]   ethertype_out;
  logic          hdr_valid_out;
  logic [CW-1:0] frames_ok_out;
  logic [CW-1:0] frames_drop_out;

  int checks = 0;
  int errors = 0;
  int hdr_pulses = 0;
  int h0;
  bit rand_ready = 1'b0;

  logic [7:0] tx_q [$];
  logic [8:0] exp_q [$];
  logic [8:0] ip_q [$];
  logic [8:0] arp_q [$];

  eth_frame_rx #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .mac_addr(mac_addr),
    .axis_tdata_in(axis_tdata_in), .axis_tvalid_in(axis_tvalid_in),
    .axis_tlast_in(axis_tlast_in), .axis_tready_o(axis_tready_o),
    .ip_tdata_out(ip_tdata_out), .ip_tvalid_out(ip_tvalid_out),
    .ip_tlast_out(ip_tlast_out), .ip_tready_in(ip_tready_in),
    .arp_tdata_out(arp_tdata_out), .arp_tvalid_out(arp_tvalid_out),
    .arp_tlast_out(arp_tlast_out), .arp_tready_in(arp_tready_in),
    .src_mac_out(src_mac_out), .ethertype_out(ethertype_out),
    .hdr_valid_out(hdr_valid_out),
    .frames_ok_out(frames_ok_out), .frames_drop_out(frames_drop_out)
  );

  always #5 clk = ~clk;

  // Downstream ready: constant 1, or a coin toss each cycle
  always @(negedge clk) begin
    if (rand_ready) ip_tready_in = 1'($urandom_range(0, 1));
    else            ip_tready_in = 1'b1;
  end

  // Output monitor: a valid&ready pair seen mid-cycle transfers at the next edge
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (ip_tvalid_out && ip_tready_in)   ip_q.push_back({ip_tlast_out, ip_tdata_out});
      if (arp_tvalid_out && arp_tready_in) arp_q.push_back({arp_tlast_out, arp_tdata_out});
      if (hdr_valid_out) hdr_pulses++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int n, input logic [7:0] base);
    logic [7:0] b;
    tx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(src[47-8*i -: 8]);
    tx_q.push_back(et[15:8]);
    tx_q.push_back(et[7:0]);
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      tx_q.push_back(b);
      exp_q.push_back({(i == n - 1), b});
    end
  endtask

  task automatic send(input int n, input bit with_last);
    int t;
    bit done;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      axis_tvalid_in = 1'b1;
      axis_tdata_in  = tx_q[i];
      axis_tlast_in  = with_last && (i == n - 1);
      t = 0;
      done = 1'b0;
      while (!done) begin
        #1;
        done = axis_tready_o;
        @(posedge clk);
        if (!done) begin
          t++;
          if (t > 2000) begin
            check_val("send_timeout", 64'(i), 64'(n));
            axis_tvalid_in = 1'b0;
            axis_tlast_in  = 1'b0;
            return;
          end
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    axis_tvalid_in = 1'b0;
    axis_tlast_in  = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 500 && !idle; t++) begin
      @(negedge clk);
      #3;
      idle = !ip_tvalid_out && !arp_tvalid_out;
    end
    if (!idle) check_val("drain_timeout", 64'(idle), 64'd1);
  endtask

  task automatic check_stream(input string tag, input bit arp);
    int sz;
    logic [8:0] got;
    sz = arp ? arp_q.size() : ip_q.size();
    check_val({tag, "_len"}, 64'(sz), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sz) begin
        got = arp ? arp_q[i] : ip_q[i];
        check_val($sformatf("%s_b%0d", tag, i), 64'(got), 64'(exp_q[i]));
      end
    end
    ip_q.delete();
    arp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_ip_tvalid",  64'(ip_tvalid_out), 64'd0);
    check_val("rst_arp_tvalid", 64'(arp_tvalid_out), 64'd0);
    check_val("rst_hdr_valid",  64'(hdr_valid_out), 64'd0);
    check_val("rst_ip_tdata",   64'(ip_tdata_out), 64'd0);
    check_val("rst_src_mac",    64'(src_mac_out), 64'd0);
    check_val("rst_ethertype",  64'(ethertype_out), 64'd0);
    check_val("rst_ok",         64'(frames_ok_out), 64'd0);
    check_val("rst_drop",       64'(frames_drop_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_tready", 64'(axis_tready_o), 64'd1);

    // Unicast IPv4, 20-byte payload
    h0 = hdr_pulses;
    build(MY_MAC, SRC1, 16'h0800, 20, 8'h00);
    send(tx_q.size(), 1'b1);
    drain();
    check_val("ip_arp_idle", 64'(arp_q.size()), 64'd0);
    check_stream("ip_basic", 1'b0);
    check_val("ip_hdr_pulse", 64'(hdr_pulses - h0), 64'd1);
    check_val("ip_ethertype", 64'(ethertype_out), 64'h0800);
    check_val("ip_src_mac", 64'(src_mac_out), 64'(SRC1));
    check_val("ip_ok", 64'(frames_ok_out), 64'd1);

    // Broadcast ARP, 28-byte payload
    h0 = hdr_pulses;
    build(BCAST, SRC2, 16'h0806, 28, 8'hA0);
    send(tx_q.size(), 1'b1);
    drain();
    check_val("arp_ip_idle", 64'(ip_q.size()), 64'd0);
    check_stream("arp_bcast", 1'b1);
    check_val("arp_hdr_pulse", 64'(hdr_pulses - h0), 64'd1);
    check_val("arp_ethertype", 64'(ethertype_out), 64'h0806);
    check_val("arp_src_mac", 64'(src_mac_out), 64'(SRC2));
    check_val("arp_ok", 64'(frames_ok_out), 64'd2);

    // Foreign destination is dropped, then a valid frame passes
    h0 = hdr_pulses;
    build(OTHER, SRC1, 16'h0800, 40, 8'h40);
    send(tx_q.size(), 1'b1);
    drain();
    check_val("foreign_out", 64'(ip_q.size() + arp_q.size()), 64'd0);
    check_val("foreign_hdr", 64'(hdr_pulses - h0), 64'd0);
    check_val("foreign_drop", 64'(frames_drop_out), 64'd1);
    check_val("foreign_src_held", 64'(src_mac_out), 64'(SRC2));
    build(MY_MAC, SRC1, 16'h0800, 12, 8'h70);
    send(tx_q.size(), 1'b1);
    drain();
    check_stream("after_foreign", 1'b0);
    check_val("after_foreign_ok", 64'(frames_ok_out), 64'd3);

    // 10-byte runt, then a short valid frame
    h0 = hdr_pulses;
    build(MY_MAC, SRC1, 16'h0800, 0, 8'h00);
    send(10, 1'b1);
    drain();
    check_val("runt10_out", 64'(ip_q.size() + arp_q.size()), 64'd0);
    check_val("runt10_hdr", 64'(hdr_pulses - h0), 64'd0);
    check_val("runt10_drop", 64'(frames_drop_out), 64'd2);
    build(MY_MAC, SRC2, 16'h0800, 5, 8'h90);
    send(tx_q.size(), 1'b1);
    drain();
    check_stream("after_runt", 1'b0);
    check_val("after_runt_src", 64'(src_mac_out), 64'(SRC2));
    check_val("after_runt_ok", 64'(frames_ok_out), 64'd4);

    // Random downstream back-pressure
    rand_ready = 1'b1;
    build(MY_MAC, SRC1, 16'h0800, 64, 8'h10);
    send(tx_q.size(), 1'b1);
    drain();
    rand_ready = 1'b0;
    check_stream("ip_stall", 1'b0);
    check_val("ip_stall_ok", 64'(frames_ok_out), 64'd5);

    // tlast on header byte 13 is still a runt; then saturate the drop counter
    h0 = hdr_pulses;
    build(MY_MAC, SRC1, 16'h0800, 0, 8'h00);
    send(14, 1'b1);
    drain();
    check_val("runt14_out", 64'(ip_q.size() + arp_q.size()), 64'd0);
    check_val("runt14_hdr", 64'(hdr_pulses - h0), 64'd0);
    check_val("runt14_drop", 64'(frames_drop_out), 64'd3);
    for (int k = 0; k < 7; k++) send(2, 1'b1);
    @(negedge clk);
    #1;
    check_val("drop_saturate", 64'(frames_drop_out), 64'd7);
    check_val("sat_ok_held", 64'(frames_ok_out), 64'd5);

    // Reset in the middle of a payload
    build(MY_MAC, SRC2, 16'h0800, 20, 8'h30);
    send(19, 1'b0);
    reset = 1'b1;
    #1;
    check_val("midrst_ip_tvalid", 64'(ip_tvalid_out), 64'd0);
    check_val("midrst_ip_tlast",  64'(ip_tlast_out), 64'd0);
    check_val("midrst_ip_tdata",  64'(ip_tdata_out), 64'd0);
    check_val("midrst_src_mac",   64'(src_mac_out), 64'd0);
    check_val("midrst_ethertype", 64'(ethertype_out), 64'd0);
    check_val("midrst_ok",        64'(frames_ok_out), 64'd0);
    check_val("midrst_drop",      64'(frames_drop_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ip_q.delete();
    arp_q.delete();
    build(MY_MAC, SRC1, 16'h0800, 16, 8'h50);
    send(tx_q.size(), 1'b1);
    drain();
    check_stream("post_rst", 1'b0);
    check_val("post_rst_src", 64'(src_mac_out), 64'(SRC1));
    check_val("post_rst_ok", 64'(frames_ok_out), 64'd1);
    check_val("post_rst_drop", 64'(frames_drop_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
